weight_load_sequencer: RTL and testbench

//  Streams all FNN weights from an external weight ROM/RAM onto the shared weight_bus of Layer1..Layer4.

---
 rtl/weight_load_sequencer.sv | 158 +++++++++++++++
 tb/tb_weight_load_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/weight_load_sequencer.sv
// weight_load_sequencer: streams all FNN layer weights from memory onto the shared weight bus
module weight_load_sequencer #(
    parameter int WEIGHT_WIDTH  = 16,
    parameter int PART_NO_WIDTH = 7,
    parameter int NO_INPUTS     = 784,
    parameter int NN_L1         = 40,
    parameter int NN_L2         = 10,
    parameter int NN_L3         = 10,
    parameter int NN_L4         = 10,
    parameter int ADDR_WIDTH    = 16,
    parameter int BASE_ADDR     = 0
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start_load,
    input  logic                                pause,
    input  logic [3:0]                          layer_ready,
    input  logic [WEIGHT_WIDTH-1:0]             mem_rdata,
    output logic                                mem_rd_en,
    output logic [ADDR_WIDTH-1:0]               mem_addr,
    output logic [PART_NO_WIDTH+WEIGHT_WIDTH-1:0] weight_bus,
    output logic                                weight_valid,
    output logic [3:0]                          load_weights,
    output logic                                busy,
    output logic                                load_done,
    output logic                                weights_loaded
);
    localparam int AW = ADDR_WIDTH;
    localparam int PW = PART_NO_WIDTH;
    localparam int BW = PART_NO_WIDTH + WEIGHT_WIDTH;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, WAIT_RDY} state_t;

    state_t          state_q, state_d;
    logic [1:0]      lyr_q, lyr_d;
    logic [AW-1:0]   w_cnt_q, w_cnt_d, addr_q, addr_d, raddr_q, raddr_d, fan_last;
    logic [PW-1:0]   n_cnt_q, n_cnt_d, tag1_q, tag1_d, tag2_q, tag2_d, nrn_last;
    logic            rd_q, rd_d, pend_q, pend_d, wv_q, wv_d;
    logic [BW-1:0]   bus_q, bus_d;
    logic [3:0]      lw_q, lw_d;
    logic            busy_q, busy_d, done_q, done_d, loaded_q, loaded_d;

    // Last weight index and last neuron index of the layer currently being filled
    always_comb begin
        fan_last = lyr_q == 2'd0 ? AW'(NO_INPUTS - 1) : lyr_q == 2'd1 ? AW'(NN_L1 - 1) :
                   lyr_q == 2'd2 ? AW'(NN_L2 - 1) : AW'(NN_L3 - 1);
        nrn_last = lyr_q == 2'd0 ? PW'(NN_L1 - 1) : lyr_q == 2'd1 ? PW'(NN_L2 - 1) :
                   lyr_q == 2'd2 ? PW'(NN_L3 - 1) : PW'(NN_L4 - 1);
    end

    // Next-state: FSM, counters, and the read pipeline carrying the part tag alongside the data
    always_comb begin
        state_d  = state_q;
        lyr_d    = lyr_q;
        w_cnt_d  = w_cnt_q;
        n_cnt_d  = n_cnt_q;
        addr_d   = addr_q;
        rd_d     = 1'b0;
        raddr_d  = raddr_q;
        tag1_d   = tag1_q;
        pend_d   = rd_q;
        tag2_d   = tag1_q;
        wv_d     = pend_q;
        bus_d    = pend_q ? {mem_rdata, tag2_q} : bus_q;
        lw_d     = lw_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        loaded_d = loaded_q;
        case (state_q)
            IDLE: if (start_load) begin
                state_d  = STREAM;
                loaded_d = 1'b0;
                busy_d   = 1'b1;
                lyr_d    = 2'd0;
                addr_d   = AW'(BASE_ADDR);
                w_cnt_d  = '0;
                n_cnt_d  = '0;
                lw_d     = 4'b0001;
            end
            STREAM: if (!pause) begin
                rd_d    = 1'b1;
                raddr_d = addr_q;
                tag1_d  = n_cnt_q;
                addr_d  = addr_q + 1'b1;
                w_cnt_d = w_cnt_q == fan_last ? '0 : w_cnt_q + 1'b1;
                if (w_cnt_q == fan_last) begin
                    n_cnt_d = n_cnt_q + 1'b1;
                    if (n_cnt_q == nrn_last) state_d = DRAIN;
                end
            end
            DRAIN: state_d = WAIT_RDY;
            WAIT_RDY: if (layer_ready[lyr_q]) begin
                if (lyr_q == 2'd3) begin
                    state_d  = IDLE;
                    done_d   = 1'b1;
                    loaded_d = 1'b1;
                    busy_d   = 1'b0;
                    lw_d     = 4'b0000;
                end else begin
                    state_d = STREAM;
                    lyr_d   = lyr_q + 2'd1;
                    lw_d    = lw_q << 1;
                    w_cnt_d = '0;
                    n_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts everything including words in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            lyr_q    <= '0;
            w_cnt_q  <= '0;
            n_cnt_q  <= '0;
            addr_q   <= '0;
            rd_q     <= 1'b0;
            raddr_q  <= '0;
            tag1_q   <= '0;
            pend_q   <= 1'b0;
            tag2_q   <= '0;
            wv_q     <= 1'b0;
            bus_q    <= '0;
            lw_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            loaded_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            lyr_q    <= lyr_d;
            w_cnt_q  <= w_cnt_d;
            n_cnt_q  <= n_cnt_d;
            addr_q   <= addr_d;
            rd_q     <= rd_d;
            raddr_q  <= raddr_d;
            tag1_q   <= tag1_d;
            pend_q   <= pend_d;
            tag2_q   <= tag2_d;
            wv_q     <= wv_d;
            bus_q    <= bus_d;
            lw_q     <= lw_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            loaded_q <= loaded_d;
        end
    end

    assign mem_rd_en      = rd_q;
    assign mem_addr       = raddr_q;
    assign weight_bus     = bus_q;
    assign weight_valid   = wv_q;
    assign load_weights   = lw_q;
    assign busy           = busy_q;
    assign load_done      = done_q;
    assign weights_loaded = loaded_q;
endmodule

// File: tb/tb_weight_load_sequencer.sv
// tb_weight_load_sequencer: scoreboard bench for the weight load sequencer on a small network
module tb_weight_load_sequencer;
    localparam int WW = 16;
    localparam int PW = 7;
    localparam int AW = 16;
    localparam int TOTAL = 26;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start_load = 1'b0;
    logic          pause = 1'b0;
    logic [3:0]    layer_ready = 4'hF;
    logic [WW-1:0] mem_rdata = '0;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [PW+WW-1:0] weight_bus;
    logic          weight_valid;
    logic [3:0]    load_weights;
    logic          busy, load_done, weights_loaded;

    weight_load_sequencer #(
        .WEIGHT_WIDTH(WW), .PART_NO_WIDTH(PW), .NO_INPUTS(4), .NN_L1(3), .NN_L2(2),
        .NN_L3(2), .NN_L4(2), .ADDR_WIDTH(AW), .BASE_ADDR(0)
    ) dut (
        .clk(clk), .reset(reset), .start_load(start_load), .pause(pause),
        .layer_ready(layer_ready), .mem_rdata(mem_rdata), .mem_rd_en(mem_rd_en),
        .mem_addr(mem_addr), .weight_bus(weight_bus), .weight_valid(weight_valid),
        .load_weights(load_weights), .busy(busy), .load_done(load_done),
        .weights_loaded(weights_loaded)
    );

    always #5 clk = ~clk;

    // Memory model: mem[a] = a, one-cycle synchronous read
    always @(posedge clk) if (mem_rd_en) mem_rdata <= mem_addr;

    int checks = 0;
    int errors = 0;
    logic [PW+WW-1:0] exp_q[$];
    int lay_of[TOTAL];
    int exp_addr = 0;
    int wv_n = 0;
    int done_n = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Expected stream: layer by layer, neuron by neuron, data equals address
    task automatic push_all();
        int fan[4] = '{4, 3, 2, 2};
        int nn[4]  = '{3, 2, 2, 2};
        int a = 0;
        for (int l = 0; l < 4; l++)
            for (int n = 0; n < nn[l]; n++)
                for (int w = 0; w < fan[l]; w++) begin
                    exp_q.push_back({WW'(a), PW'(n)});
                    lay_of[a] = l;
                    a++;
                end
    endtask

    // Monitor: pop the scoreboard on every presented word, track issued reads
    always @(negedge clk) begin
        if (weight_valid) begin
            wv_n++;
            if (exp_q.size() == 0) check("extra_word", 32'(weight_valid), 0);
            else check("word", 32'(weight_bus), 32'(exp_q.pop_front()));
        end
        if (mem_rd_en) begin
            if (exp_addr >= TOTAL) check("extra_read", 32'(mem_rd_en), 0);
            else begin
                check("addr", 32'(mem_addr), exp_addr);
                check("lw", 32'(load_weights), 1 << lay_of[exp_addr]);
                check("busy_rd", 32'(busy), 1);
            end
            exp_addr++;
        end
        if (load_done) done_n++;
    end

    task automatic start(input bit push);
        int lat = 0;
        if (push) begin
            wv_n = 0;
            done_n = 0;
            exp_addr = 0;
            push_all();
        end
        @(negedge clk) start_load = 1'b1;
        @(negedge clk) start_load = 1'b0;
        if (push) begin
            check("loaded_clr", 32'(weights_loaded), 0);
            check("busy_set", 32'(busy), 1);
            while (!weight_valid && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            check("latency", lat, 3);
        end
    endtask

    task automatic wait_done();
        int t = 0;
        while (!load_done && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("done_seen", 32'(load_done), 1);
        repeat (2) @(negedge clk);
        check("wv_total", wv_n, TOTAL);
        check("sb_empty", exp_q.size(), 0);
        check("done_once", done_n, 1);
        check("loaded", 32'(weights_loaded), 1);
        check("busy_clr", 32'(busy), 0);
        check("lw_clr", 32'(load_weights), 0);
    endtask

    task automatic wait_addr(input int n);
        int t = 0;
        while (exp_addr < n && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("addr_reach", 32'(exp_addr >= n), 1);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_rd"}, 32'(mem_rd_en), 0);
        check({tag, "_addr"}, 32'(mem_addr), 0);
        check({tag, "_bus"}, 32'(weight_bus), 0);
        check({tag, "_wv"}, 32'(weight_valid), 0);
        check({tag, "_lw"}, 32'(load_weights), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(load_done), 0);
        check({tag, "_loaded"}, 32'(weights_loaded), 0);
    endtask

    initial begin
        int t;
        repeat (3) @(negedge clk);
        check_idle("rst");
        reset = 1'b0;
        // Full load with every layer ready
        start(1);
        wait_done();
        // Layer 1 ready withheld while other layers claim ready
        layer_ready = 4'b1110;
        start(1);
        wait_addr(12);
        repeat (20) @(negedge clk);
        check("hold_addr", exp_addr, 12);
        check("hold_rd", 32'(mem_rd_en), 0);
        check("hold_busy", 32'(busy), 1);
        check("hold_lw", 32'(load_weights), 4'b0001);
        layer_ready = 4'hF;
        wait_addr(13);
        wait_done();
        // Pause for three cycles mid layer 1
        start(1);
        wait_addr(6);
        pause = 1'b1;
        repeat (3) @(negedge clk);
        check("pause_rd", 32'(mem_rd_en), 0);
        pause = 1'b0;
        wait_done();
        // Start re-pulsed while busy must not restart
        start(1);
        wait_addr(5);
        start(0);
        wait_done();
        // Reset after the seventh word, then restart from the base address
        start(1);
        t = 0;
        while (wv_n < 7 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("wv7_reach", 32'(wv_n >= 7), 1);
        reset = 1'b1;
        @(negedge clk);
        check_idle("abort");
        reset = 1'b0;
        exp_q.delete();
        start(1);
        wait_done();
        // Reset and start together: reset wins
        @(negedge clk);
        reset = 1'b1;
        start_load = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start_load = 1'b0;
        repeat (4) @(negedge clk);
        check("rs_busy", 32'(busy), 0);
        check("rs_rd", 32'(mem_rd_en), 0);
        check("rs_lw", 32'(load_weights), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
